// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    // Operation select as presented on the op port.
    typedef enum logic [1:0] {
        OP_MULLO = 2'd0,
        OP_MULHI = 2'd1,
        OP_DIVU  = 2'd2,
        OP_REMU  = 2'd3
    } op_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Divide-class ops share the restoring-division datapath.
    function automatic logic is_div(input op_e o);
        return (o == OP_DIVU) || (o == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with a held write-back request.
// A single 2*DBITS+1 accumulator is shared: shift-add (right) for multiply,
// restoring division (left) for divide.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [DBITS-1:0] rs1_val,
    input  logic [DBITS-1:0] rs2_val,
    input  logic [3:0]       rd_in,
    output logic             busy,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [3:0]       wb_rd,
    output logic [DBITS-1:0] wb_data
);

    localparam int CW = $clog2(DBITS) + 1;
    localparam int AW = 2 * DBITS + 1;

    state_e           state;
    op_e              op_q;
    op_e              op_in;
    logic [DBITS-1:0] opnd_q;     // multiplicand A, or divisor
    logic [AW-1:0]    acc;        // {upper/rem (DBITS+1), lower/quotient (DBITS)}
    logic [AW-1:0]    acc_next;
    logic [CW-1:0]    cnt;
    logic [DBITS:0]   mul_sum;
    logic [AW-1:0]    div_sh;
    logic [DBITS:0]   div_diff;
    logic [DBITS-1:0] result_next;

    assign op_in = op_e'(op);

    // One iteration of the active algorithm, computed from the current accumulator.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        mul_sum  = '0;
        div_sh   = '0;
        div_diff = '0;
        acc_next = acc;
        if (is_div(op_q)) begin
            // Shift {rem, quotient} left; the dividend MSB moves into rem.
            div_sh   = acc << 1;
            div_diff = div_sh[AW-1:DBITS] - {1'b0, opnd_q};
            acc_next = div_sh;
            if (div_sh[AW-1:DBITS] >= {1'b0, opnd_q}) begin
                acc_next[AW-1:DBITS] = div_diff;
                acc_next[0]          = 1'b1;
            end
        end else begin
            // Conditionally add A into the upper half with carry, then shift right.
            mul_sum = {1'b0, acc[2*DBITS-1:DBITS]} + {1'b0, opnd_q};
            if (acc[0]) begin
                acc_next = {1'b0, mul_sum, acc[DBITS-1:1]};
            end else begin
                acc_next = {2'b00, acc[2*DBITS-1:1]};
            end
        end
    end

    // Select the requested half of the accumulator after the final iteration.
    always_comb begin
        result_next = '0;
        case (op_q)
            OP_MULLO: result_next = acc_next[DBITS-1:0];
            OP_MULHI: result_next = acc_next[2*DBITS-1:DBITS];
            OP_DIVU:  result_next = acc_next[DBITS-1:0];
            default:  result_next = acc_next[2*DBITS-1:DBITS];
        endcase
    end

    // Controller FSM with registered busy/write-back outputs.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_q     <= OP_MULLO;
            opnd_q   <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= op_in;
                        wb_rd <= rd_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        if (is_div(op_in) && (rs2_val == '0)) begin
                            // Divide by zero skips iteration entirely.
                            state    <= ST_DONE;
                            wb_valid <= 1'b1;
                            wb_data  <= (op_in == OP_DIVU) ? '1 : rs1_val;
                        end else begin
                            state  <= ST_RUN;
                            opnd_q <= is_div(op_in) ? rs2_val : rs1_val;
                            acc    <= {{(DBITS+1){1'b0}}, is_div(op_in) ? rs1_val : rs2_val};
                        end
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DBITS - 1)) begin
                        state    <= ST_DONE;
                        wb_valid <= 1'b1;
                        wb_data  <= result_next;
                    end
                end
                ST_DONE: begin
                    if (wb_ready) begin
                        state    <= ST_IDLE;
                        wb_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wb_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int DBITS = 32;
    localparam int LAT   = DBITS;
    localparam int LIMIT = 200;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [DBITS-1:0] rs1_val;
    logic [DBITS-1:0] rs2_val;
    logic [3:0]       rd_in;
    logic             busy;
    logic             wb_valid;
    logic             wb_ready;
    logic [3:0]       wb_rd;
    logic [DBITS-1:0] wb_data;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.DBITS(DBITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .rd_in    (rd_in),
        .busy     (busy),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain wide arithmetic, with the divide-by-zero convention.
    function automatic logic [DBITS-1:0] ref_result(input logic [1:0] o,
                                                    input logic [DBITS-1:0] a,
                                                    input logic [DBITS-1:0] b);
        logic [2*DBITS-1:0] p;
        p = {{DBITS{1'b0}}, a} * {{DBITS{1'b0}}, b};
        case (o)
            2'd0:    return p[DBITS-1:0];
            2'd1:    return p[2*DBITS-1:DBITS];
            2'd2:    return (b == 0) ? {DBITS{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [DBITS-1:0] rand_divisor();
        if ($urandom_range(0, 2) == 0) return DBITS'($urandom_range(1, 20));
        return DBITS'($urandom);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns just after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [DBITS-1:0] a,
                         input logic [DBITS-1:0] b, input logic [3:0] r);
        start   = 1'b1;
        op      = o;
        rs1_val = a;
        rs2_val = b;
        rd_in   = r;
        step();
        start   = 1'b0;
        rs1_val = DBITS'($urandom);
        rs2_val = DBITS'($urandom);
        rd_in   = 4'($urandom);
    endtask

    // Count edges until wb_valid is seen, bounded.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (wb_valid !== 1'b1 && cyc < LIMIT) begin
            step();
            cyc++;
        end
    endtask

    // One full transaction: latency, data, rd and release of busy.
    task automatic test_op(input string name, input logic [1:0] o,
                           input logic [DBITS-1:0] a, input logic [DBITS-1:0] b,
                           input bit early_ready);
        logic [3:0]       r;
        logic [DBITS-1:0] exp;
        int               cyc;
        bit               lat_ok;
        r   = 4'($urandom);
        exp = ref_result(o, a, b);
        issue(o, a, b, r);
        wb_ready = early_ready;
        wait_valid(cyc);
        lat_ok = (o[1] && b == 0) ? (cyc <= 1) : (cyc == LAT);
        checks++;
        if (!lat_ok) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles", name, cyc);
        end
        checks++;
        if (wb_data !== exp) begin
            errors++;
            $display("FAIL %s data: got %h expected %h (a=%h b=%h)", name, wb_data, exp, a, b);
        end
        checks++;
        if (wb_rd !== r) begin
            errors++;
            $display("FAIL %s rd: got %h expected %h", name, wb_rd, r);
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s release: busy=%b wb_valid=%b expected 0/0", name, busy, wb_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        op    = 2'd0;
        step();
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || wb_rd !== 4'd0 || wb_data !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b rd=%h data=%h expected all 0",
                     busy, wb_valid, wb_rd, wb_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mul();
        test_op("mullo_dir", 2'd0, 32'h0001_0003, 32'h0002_0005, 1'b0);
        test_op("mulhi_ones", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        test_op("mullo_ones", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        test_op("mul_zero", 2'd1, 32'h0, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 12; i++) begin
            test_op("mul_rand", 2'($urandom_range(0, 1)), DBITS'($urandom),
                    DBITS'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_div();
        test_op("divu_dir", 2'd2, 32'd100, 32'd7, 1'b0);
        test_op("remu_dir", 2'd3, 32'd100, 32'd7, 1'b0);
        test_op("divu_big", 2'd2, 32'hFFFF_FFFF, 32'h1, 1'b0);
        test_op("remu_small", 2'd3, 32'd3, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 12; i++) begin
            test_op("div_rand", 2'($urandom_range(2, 3)), DBITS'($urandom),
                    rand_divisor(), 1'($urandom));
        end
    endtask

    task automatic test_div_zero();
        test_op("divu_zero", 2'd2, 32'd5, 32'd0, 1'b0);
        test_op("remu_zero", 2'd3, 32'd5, 32'd0, 1'b0);
        test_op("remu_zero_rand", 2'd3, DBITS'($urandom), 32'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [DBITS-1:0] a, b, exp;
        logic [3:0]       r;
        int               cyc;
        a   = DBITS'($urandom);
        b   = DBITS'($urandom);
        r   = 4'hA;
        exp = ref_result(2'd1, a, b);
        issue(2'd1, a, b, r);
        // Stray request during RUN must not restart or retarget.
        repeat (5) step();
        start = 1'b1; op = 2'd2; rs1_val = 32'd9; rs2_val = 32'd0; rd_in = 4'h3;
        step();
        start = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc + 6 != LAT) begin
            errors++;
            $display("FAIL bp_latency: got %0d cycles expected %0d", cyc + 6, LAT);
        end
        // Held in DONE with stray starts and no ready.
        for (int i = 0; i < 10; i++) begin
            start   = 1'($urandom);
            op      = 2'($urandom);
            rs2_val = 32'd0;
            rd_in   = 4'h5;
            step();
            checks++;
            if (wb_valid !== 1'b1 || wb_data !== exp || wb_rd !== r) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h rd=%h expected 1 %h %h",
                         i, wb_valid, wb_data, wb_rd, 1'b1, exp, r);
            end
        end
        start    = 1'b0;
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: busy=%b valid=%b expected 0 0", busy, wb_valid);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        issue(2'd0, DBITS'($urandom), DBITS'($urandom), 4'h7);
        repeat (14) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_run: busy=%b valid=%b expected 0 0", busy, wb_valid);
        end
        repeat (LAT + 2) step();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_run_stale: valid=%b expected 0", wb_valid);
        end
        test_op("after_reset", 2'd3, DBITS'($urandom), rand_divisor(), 1'b0);
        // Reset wins over a handshake in DONE.
        issue(2'd2, 32'd77, 32'd0, 4'h9);
        wait_valid(cyc);
        rst_n    = 1'b0;
        wb_ready = 1'b1;
        step();
        rst_n    = 1'b1;
        wb_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || wb_rd !== 4'd0 || wb_data !== '0) begin
            errors++;
            $display("FAIL reset_done: busy=%b valid=%b rd=%h data=%h expected all 0",
                     busy, wb_valid, wb_rd, wb_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [DBITS-1:0] a, b, exp;
        int               cyc;
        issue(2'd0, DBITS'($urandom), DBITS'($urandom), 4'h1);
        wait_valid(cyc);
        a   = DBITS'($urandom);
        b   = rand_divisor();
        exp = ref_result(2'd2, a, b);
        // Handshake and start in the same cycle: start is ignored.
        wb_ready = 1'b1;
        start = 1'b1; op = 2'd2; rs1_val = a; rs2_val = b; rd_in = 4'hC;
        step();
        wb_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignored: busy=%b valid=%b expected 0 0", busy, wb_valid);
        end
        issue(2'd2, a, b, 4'hC);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b expected 1", busy);
        end
        wait_valid(cyc);
        checks++;
        if (cyc != LAT || wb_data !== exp || wb_rd !== 4'hC) begin
            errors++;
            $display("FAIL b2b_result: cyc=%0d data=%h rd=%h expected %0d %h c",
                     cyc, wb_data, wb_rd, LAT, exp);
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 2'd0;
        rs1_val  = '0;
        rs2_val  = '0;
        rd_in    = '0;
        wb_ready = 1'b0;
        step();
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
